// File: rtl/median_pkg.sv
// Shared types and constants for the 5x5 median window path.
package median_pkg;

    localparam int WIN_SIZE = 5;
    localparam int PIX_W    = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_e;

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port line buffer: combinational read, synchronous write, contents not reset.
module line_buffer_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port: the read of the same address this cycle still sees the old word.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/axis_column_window_5x5.sv
// Raster AXI-Stream to vertical 5-pixel column feeder for the 5x5 median sorter.
// Build option MEDIAN_BORDER_REPLICATE_EN: replicate the top frame row upward instead of zero padding.
module axis_column_window_5x5
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] o_num_0,
    output logic [DATA_WIDTH-1:0] o_num_1,
    output logic [DATA_WIDTH-1:0] o_num_2,
    output logic [DATA_WIDTH-1:0] o_num_3,
    output logic [DATA_WIDTH-1:0] o_num_4,
    output logic                  o_valid,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_rows_ok,
    output logic                  o_err
);

    localparam int               COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [2:0]       ROW_MAX  = 3'(WIN_SIZE - 1);

    state_e                state_r, state_next_s;
    logic                  tready_r;
    logic [COL_W-1:0]      col_r, col_next_s, col_eff_s;
    logic [2:0]            row_r, row_next_s, row_eff_s;
    logic                  err_r, err_next_s;
    logic                  accept_s, proc_s, is_sof_s, last_col_s, eol_s, frame_err_s;

    logic [DATA_WIDTH-1:0] rd1_s, rd2_s, rd3_s, rd4_s;
    logic [DATA_WIDTH-1:0] tap_s [WIN_SIZE];
    logic [DATA_WIDTH-1:0] win_s [WIN_SIZE];
    logic [DATA_WIDTH-1:0] pad_s;

    logic                  valid_r, sof_r, eol_r, rows_ok_r;
    logic [DATA_WIDTH-1:0] num_r [WIN_SIZE];

    assign accept_s    = s_axis_tvalid && tready_r;
    assign is_sof_s    = accept_s && s_axis_tuser;
    // An accepted SOF overrides the running position so the beat lands at (0,0).
    assign col_eff_s   = is_sof_s ? {COL_W{1'b0}} : col_r;
    assign row_eff_s   = is_sof_s ? 3'd0 : row_r;
    assign last_col_s  = (col_eff_s == LAST_COL);
    assign eol_s       = s_axis_tlast || last_col_s;
    assign frame_err_s = s_axis_tlast ^ last_col_s;

    // Line buffer chain: each buffer shifts its old word into the next one.
    line_buffer_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb1 (
        .i_clk (i_clk), .we (proc_s), .addr (col_eff_s), .wdata (s_axis_tdata), .rdata (rd1_s)
    );
    line_buffer_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb2 (
        .i_clk (i_clk), .we (proc_s), .addr (col_eff_s), .wdata (rd1_s), .rdata (rd2_s)
    );
    line_buffer_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb3 (
        .i_clk (i_clk), .we (proc_s), .addr (col_eff_s), .wdata (rd2_s), .rdata (rd3_s)
    );
    line_buffer_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb4 (
        .i_clk (i_clk), .we (proc_s), .addr (col_eff_s), .wdata (rd3_s), .rdata (rd4_s)
    );

    // Column assembly with padding for rows above the top of the frame.
    always_comb begin
        tap_s[0] = s_axis_tdata;
        tap_s[1] = rd1_s;
        tap_s[2] = rd2_s;
        tap_s[3] = rd3_s;
        tap_s[4] = rd4_s;
`ifdef MEDIAN_BORDER_REPLICATE_EN
        pad_s    = tap_s[row_eff_s];
`else
        pad_s    = {DATA_WIDTH{1'b0}};
`endif
        for (int k = 0; k < WIN_SIZE; k++) begin
            if (3'(k) <= row_eff_s) begin
                win_s[k] = tap_s[k];
            end else begin
                win_s[k] = pad_s;
            end
        end
    end

    // Next-state logic: frame gating, position counters and sticky framing error.
    always_comb begin
        state_next_s = state_r;
        col_next_s   = col_r;
        row_next_s   = row_r;
        err_next_s   = err_r;
        case (state_r)
            WAIT_SOF: proc_s = is_sof_s;
            ACTIVE:   proc_s = accept_s;
            default:  proc_s = 1'b0;
        endcase
        if (proc_s) begin
            state_next_s = ACTIVE;
            err_next_s   = (is_sof_s ? 1'b0 : err_r) | frame_err_s;
            if (eol_s) begin
                col_next_s = {COL_W{1'b0}};
                row_next_s = (row_eff_s == ROW_MAX) ? ROW_MAX : row_eff_s + 3'd1;
            end else begin
                col_next_s = col_eff_s + COL_W'(1);
                row_next_s = row_eff_s;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_r  <= WAIT_SOF;
            tready_r <= 1'b0;
            col_r    <= {COL_W{1'b0}};
            row_r    <= 3'd0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            tready_r <= 1'b1;
            col_r    <= col_next_s;
            row_r    <= row_next_s;
            err_r    <= err_next_s;
        end
    end

    // Output registers: column data and flags hold between strobes.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            valid_r   <= 1'b0;
            sof_r     <= 1'b0;
            eol_r     <= 1'b0;
            rows_ok_r <= 1'b0;
            for (int k = 0; k < WIN_SIZE; k++) begin
                num_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            valid_r <= proc_s;
            if (proc_s) begin
                sof_r     <= is_sof_s;
                eol_r     <= eol_s;
                rows_ok_r <= (row_eff_s == ROW_MAX);
                for (int k = 0; k < WIN_SIZE; k++) begin
                    num_r[k] <= win_s[k];
                end
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign o_num_0       = num_r[0];
    assign o_num_1       = num_r[1];
    assign o_num_2       = num_r[2];
    assign o_num_3       = num_r[3];
    assign o_num_4       = num_r[4];
    assign o_valid       = valid_r;
    assign o_sof         = sof_r;
    assign o_eol         = eol_r;
    assign o_rows_ok     = rows_ok_r;
    assign o_err         = err_r;

endmodule

// File: tb/tb_axis_column_window_5x5.sv
// Directed bench for axis_column_window_5x5 at IMG_WIDTH=4, DATA_WIDTH=8.
module tb_axis_column_window_5x5;

    logic       i_clk = 1'b0;
    logic       i_areset = 1'b0;
    logic [7:0] s_axis_tdata = 8'd0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tuser = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic [7:0] o_num_0, o_num_1, o_num_2, o_num_3, o_num_4;
    logic       o_valid, o_sof, o_eol, o_rows_ok, o_err;

    int n_checks = 0;
    int n_pass   = 0;

    axis_column_window_5x5 #(.DATA_WIDTH(8), .IMG_WIDTH(4)) dut (
        .i_clk         (i_clk),
        .i_areset      (i_areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .o_num_0       (o_num_0),
        .o_num_1       (o_num_1),
        .o_num_2       (o_num_2),
        .o_num_3       (o_num_3),
        .o_num_4       (o_num_4),
        .o_valid       (o_valid),
        .o_sof         (o_sof),
        .o_eol         (o_eol),
        .o_rows_ok     (o_rows_ok),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Value seen above the top frame row.
    function automatic logic [7:0] pad(input logic [7:0] top);
`ifdef MEDIAN_BORDER_REPLICATE_EN
        return top;
`else
        return 8'd0;
`endif
    endfunction

    // One beat accepted at the next rising edge; returns 1 time unit after it.
    task automatic beat(input logic [7:0] d, input logic u, input logic l);
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(posedge i_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_k;
        logic [7:0] last_d;
        int         gap;

        // Reset state
        #2 i_areset = 1'b1;
        #10;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_num0", 32'(o_num_0), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        @(negedge i_clk);
        i_areset = 1'b0;
        idle();
        chk("tready_up", 32'(s_axis_tready), 32'd1);

        // Beats before any SOF are dropped
        beat(8'd7, 1'b0, 1'b0); chk("presof_7", 32'(o_valid), 32'd0);
        beat(8'd8, 1'b0, 1'b0); chk("presof_8", 32'(o_valid), 32'd0);
        beat(8'd9, 1'b0, 1'b0); chk("presof_9", 32'(o_valid), 32'd0);
        beat(8'd1, 1'b1, 1'b0);
        chk("sof1_valid", 32'(o_valid), 32'd1);
        chk("sof1_sof", 32'(o_sof), 32'd1);
        chk("sof1_num0", 32'(o_num_0), 32'd1);
        chk("sof1_num1", 32'(o_num_1), 32'(pad(8'd1)));
        idle();
        chk("sof1_single", 32'(o_valid), 32'd0);

        // Full frame, rows 10..50, with random idle gaps between beats
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                last_d = 8'(10 * (r + 1));
                beat(last_d, (r == 0 && c == 0), (c == 3));
                chk($sformatf("frm_valid_r%0d_c%0d", r, c), 32'(o_valid), 32'd1);
                chk($sformatf("frm_sof_r%0d_c%0d", r, c), 32'(o_sof), 32'(r == 0 && c == 0));
                chk($sformatf("frm_eol_r%0d_c%0d", r, c), 32'(o_eol), 32'(c == 3));
                chk($sformatf("frm_rok_r%0d_c%0d", r, c), 32'(o_rows_ok), 32'(r == 4));
                chk($sformatf("frm_num0_r%0d_c%0d", r, c), 32'(o_num_0), 32'(last_d));
                for (int k = 1; k < 5; k++) begin
                    exp_k = (k <= r) ? 8'(10 * (r - k + 1)) : pad(8'd10);
                    case (k)
                        1:       chk($sformatf("frm_num1_r%0d_c%0d", r, c), 32'(o_num_1), 32'(exp_k));
                        2:       chk($sformatf("frm_num2_r%0d_c%0d", r, c), 32'(o_num_2), 32'(exp_k));
                        3:       chk($sformatf("frm_num3_r%0d_c%0d", r, c), 32'(o_num_3), 32'(exp_k));
                        default: chk($sformatf("frm_num4_r%0d_c%0d", r, c), 32'(o_num_4), 32'(exp_k));
                    endcase
                end
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    idle();
                    chk("gap_valid", 32'(o_valid), 32'd0);
                    chk("gap_hold", 32'(o_num_0), 32'(last_d));
                end
            end
        end
        chk("frm_err", 32'(o_err), 32'd0);

        // Early tlast at column 2
        beat(8'd100, 1'b1, 1'b0);
        beat(8'd101, 1'b0, 1'b0);
        beat(8'd102, 1'b0, 1'b1);
        chk("early_eol", 32'(o_eol), 32'd1);
        chk("early_err", 32'(o_err), 32'd1);
        beat(8'd103, 1'b0, 1'b0);
        chk("early_next_num0", 32'(o_num_0), 32'd103);
        chk("early_next_num1", 32'(o_num_1), 32'd100);
        chk("early_next_eol", 32'(o_eol), 32'd0);
        chk("early_err_sticky", 32'(o_err), 32'd1);

        // Missing tlast: forced wrap at column 3; the SOF also clears the error
        beat(8'd200, 1'b1, 1'b0);
        chk("wrap_sof_clr_err", 32'(o_err), 32'd0);
        chk("wrap_sof", 32'(o_sof), 32'd1);
        beat(8'd201, 1'b0, 1'b0);
        beat(8'd202, 1'b0, 1'b0);
        beat(8'd203, 1'b0, 1'b0);
        chk("wrap_eol", 32'(o_eol), 32'd1);
        chk("wrap_err", 32'(o_err), 32'd1);
        beat(8'd204, 1'b0, 1'b0);
        chk("wrap_next_num1", 32'(o_num_1), 32'd200);
        chk("wrap_next_eol", 32'(o_eol), 32'd0);
        chk("wrap_next_rok", 32'(o_rows_ok), 32'd0);

        // Reset in the middle of row 2
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                beat(8'(50 + r), (r == 0 && c == 0), (c == 3));
            end
        end
        beat(8'd60, 1'b0, 1'b0);
        beat(8'd61, 1'b0, 1'b0);
        i_areset = 1'b1;
        #2;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_num0", 32'(o_num_0), 32'd0);
        chk("mid_rst_num1", 32'(o_num_1), 32'd0);
        chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
        chk("mid_rst_eol", 32'(o_eol), 32'd0);
        idle();
        @(negedge i_clk);
        i_areset = 1'b0;
        idle();
        beat(8'd62, 1'b0, 1'b0);
        chk("post_rst_drop", 32'(o_valid), 32'd0);
        beat(8'd77, 1'b1, 1'b0);
        chk("post_rst_valid", 32'(o_valid), 32'd1);
        chk("post_rst_sof", 32'(o_sof), 32'd1);
        chk("post_rst_num1", 32'(o_num_1), 32'(pad(8'd77)));
        chk("post_rst_rok", 32'(o_rows_ok), 32'd0);
        beat(8'd78, 1'b0, 1'b0);
        beat(8'd79, 1'b0, 1'b0);
        beat(8'd80, 1'b0, 1'b1);
        beat(8'd81, 1'b0, 1'b0);
        chk("post_rst_row1_num1", 32'(o_num_1), 32'd77);
        chk("post_rst_row1_num2", 32'(o_num_2), 32'(pad(8'd77)));
        chk("post_rst_row1_err", 32'(o_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
